step_event_writer: RTL
======================

STEP_EVENT_WRITER -- requirements
Module: step_event_writer

Interface
REQ-001 The block SHALL have parameter NUM_OF_ROWS, default 7, meaning tile-grid rows.
REQ-002 The block SHALL have parameter NUM_OF_COLS, default 10, meaning tile-grid columns.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries (power of 2, 2..16).
REQ-004 The block SHALL have parameter BRAK_HITS, default 2, meaning landings that destroy a BRAK tile (1..3).
REQ-005 The block SHALL have these ports: clk in 1, the single clock; reset in 1, synchronous, active-high.
REQ-006 The block SHALL have these ports: startOfFrame in 1, one-cycle frame pulse; clear in 1, level-change flush pulse.
REQ-007 The block SHALL have these ports: ev_valid in 1, ev_ready out 1, ev_row in 4, ev_col in 4, ev_type in 3; ev_type is the tile type under Bumpy.
REQ-008 The block SHALL have these ports: wr_en out 1, wr_row out 4, wr_col out 4, wr_type out 3; these form the map write command.
REQ-009 The block SHALL have these ports: coin_count out 8, overflow out 1 (sticky), fifo_level out 5.
REQ-010 Tile codes SHALL be FREE=0, REGU=1, GATE=2, COIN=3, PORT=4, SPIK=5, BRAK=6.

Function
REQ-011 ev_ready SHALL equal NOT fifo_full; an event is accepted on a cycle with ev_valid=1 and ev_ready=1 and is pushed as {row,col,type}.
REQ-012 overflow SHALL be set the cycle after ev_valid=1 with ev_ready=0, and SHALL clear only on reset.
REQ-013 FSM states SHALL be IDLE, POP and WRITE; reset and clear SHALL force IDLE.
REQ-014 IDLE SHALL go to POP when startOfFrame=1 and the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-015 POP SHALL latch and remove the head entry in a single cycle and then go to WRITE.
REQ-016 WRITE SHALL assert any resulting wr_en for exactly one cycle, then go to POP if the FIFO is non-empty, else to IDLE.
REQ-017 Latency: startOfFrame high at edge k SHALL give POP in cycle k+1 and wr_en in cycle k+2; throughput SHALL be one event per 2 cycles.
REQ-018 Events accepted during a drain SHALL be drained in the same window.
REQ-019 COIN: WRITE SHALL issue wr_type=FREE at (row,col), and coin_count SHALL increment, saturating at 255.
REQ-020 BRAK: the per-tile 2-bit hit counter SHALL increment; when it would reach BRAK_HITS, WRITE SHALL issue wr_type=FREE and the counter SHALL return to 0; otherwise no write is issued.
REQ-021 FREE, REGU, GATE, PORT, SPIK and undefined codes SHALL be consumed with no write.
REQ-022 An entry with row>=NUM_OF_ROWS or col>=NUM_OF_COLS SHALL be consumed with no write and no counter change.
REQ-023 When wr_en=0, wr_row, wr_col and wr_type SHALL hold their last values.
REQ-024 A simultaneous push and pop SHALL leave fifo_level unchanged; fifo_level SHALL report occupancy 0..FIFO_DEPTH.
REQ-025 clear SHALL take priority over push, pop and startOfFrame: it empties the FIFO, zeroes all hit counters and returns to IDLE; coin_count and overflow SHALL be preserved.
REQ-026 clear asserted in WRITE SHALL suppress that cycle's wr_en.

Reset
REQ-027 On reset=1 at a clk edge, the FSM SHALL go to IDLE and the FIFO and hit counters SHALL be emptied or zeroed.
REQ-028 During reset, wr_en, wr_row, wr_col, wr_type, coin_count, overflow and fifo_level SHALL be 0, and ev_ready SHALL be 1 from the first cycle after reset.
REQ-029 Reset asserted mid-drain SHALL abort the drain with no further writes.

Configuration
REQ-030 With STEP_EVENT_DEDUP_EN defined, an accepted event whose (row,col) equals the last pushed event's (row,col) SHALL be acknowledged but not pushed; the last-pushed register SHALL be invalidated by reset, clear and any pop that empties the FIFO.
REQ-031 Without STEP_EVENT_DEDUP_EN, every accepted event SHALL be pushed.

Verification
REQ-032 Push COIN (2,3), then startOfFrame -> wr_en=1, row 2, col 3, type FREE two cycles later; coin_count 0->1.
REQ-033 BRAK_HITS=2: push BRAK (4,1) twice across two frames -> no write in the first frame; FREE write at (4,1) in the second frame.
REQ-034 Push 5 events with FIFO_DEPTH=4, no startOfFrame -> ev_ready=0 after 4 events; overflow=1; fifo_level=4.
REQ-035 Push COIN (7,0) and SPIK (1,1), then startOfFrame -> no wr_en; coin_count unchanged.
REQ-036 Queue 3 COIN events, then pulse clear in the first WRITE cycle -> no wr_en at all; fifo_level=0; coin_count unchanged.
REQ-037 Push COIN (0,0) twice back-to-back -> with STEP_EVENT_DEDUP_EN, fifo_level=1 and one write; without it, fifo_level=2 and two writes.

Source files
------------

// File: rtl/step_event_writer.sv
// Queues tile step events and drains them into map write commands, one event per two cycles, once per frame.
// Build option STEP_EVENT_DEDUP_EN drops an event repeating the (row,col) of the last pushed event.
module step_event_writer #(
  parameter int unsigned NUM_OF_ROWS = 7,
  parameter int unsigned NUM_OF_COLS = 10,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BRAK_HITS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       clear,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [3:0] ev_row,
  input  logic [3:0] ev_col,
  input  logic [2:0] ev_type,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [3:0] wr_col,
  output logic [2:0] wr_type,
  output logic [7:0] coin_count,
  output logic       overflow,
  output logic [4:0] fifo_level
);
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NCELL = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int unsigned CW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  localparam logic [2:0] T_FREE = 3'd0;
  localparam logic [2:0] T_COIN = 3'd3;
  localparam logic [2:0] T_BRAK = 3'd6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POP   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    head_row, head_col;
  logic [2:0]    head_type;
  logic [3:0]    hold_row, hold_col;
  logic [2:0]    hold_type;
  logic [1:0]    hits [NCELL];
  logic          push, pop, dup;
  logic          in_range, brak_done, do_write;
  logic [CW-1:0] cell_idx;
  logic [2:0]    hit_inc;

  assign ev_ready = (fifo_level != 5'(FIFO_DEPTH));
  assign push     = ev_valid && ev_ready && !clear && !dup;
  assign pop      = (state == S_POP) && !clear;

  // Outcome of the latched head entry, evaluated while in WRITE
  assign in_range  = (32'(head_row) < NUM_OF_ROWS) && (32'(head_col) < NUM_OF_COLS);
  assign cell_idx  = in_range ? CW'(32'(head_row) * NUM_OF_COLS + 32'(head_col)) : '0;
  assign hit_inc   = {1'b0, hits[cell_idx]} + 3'd1;
  assign brak_done = (hit_inc == 3'(BRAK_HITS));
  assign do_write  = in_range && ((head_type == T_COIN) || ((head_type == T_BRAK) && brak_done));

  assign wr_en   = (state == S_WRITE) && !clear && !reset && do_write;
  assign wr_row  = wr_en ? head_row : hold_row;
  assign wr_col  = wr_en ? head_col : hold_col;
  assign wr_type = wr_en ? T_FREE : hold_type;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (startOfFrame && (fifo_level != 5'd0)) state_nxt = S_POP;
      S_POP:   state_nxt = S_WRITE;
      S_WRITE: state_nxt = ((fifo_level != 5'd0) || push) ? S_POP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_row, ev_col, ev_type};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + 5'(push) - 5'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_row  <= '0;
      head_col  <= '0;
      head_type <= '0;
    end else if (pop) begin
      {head_row, head_col, head_type} <= mem[rd_ptr];
    end
  end

  // Coin tally, brick hit counters, sticky overflow and held write command
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_count <= '0;
      overflow   <= 1'b0;
      hold_row   <= '0;
      hold_col   <= '0;
      hold_type  <= '0;
      for (int unsigned i = 0; i < NCELL; i++) hits[i] <= '0;
    end else begin
      if (ev_valid && !ev_ready) overflow <= 1'b1;
      if (clear) begin
        for (int unsigned i = 0; i < NCELL; i++) hits[i] <= '0;
      end else if ((state == S_WRITE) && in_range) begin
        if ((head_type == T_COIN) && (coin_count != 8'hFF)) coin_count <= coin_count + 8'd1;
        if (head_type == T_BRAK) hits[cell_idx] <= brak_done ? 2'd0 : hit_inc[1:0];
      end
      if (wr_en) begin
        hold_row  <= head_row;
        hold_col  <= head_col;
        hold_type <= T_FREE;
      end
    end
  end

`ifdef STEP_EVENT_DEDUP_EN
  logic [3:0] last_row, last_col;
  logic       last_valid;

  assign dup = last_valid && (ev_row == last_row) && (ev_col == last_col);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      last_row   <= '0;
      last_col   <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_row   <= ev_row;
      last_col   <= ev_col;
      last_valid <= 1'b1;
    end else if (pop && (fifo_level == 5'd1)) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

endmodule
